// File: rtl/uart_rx_fifo.sv
// 16x-oversampling UART receiver with a character FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the err_parity_pulse output.
module uart_rx_fifo #(
  parameter int BAUD_DIV   = 651,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            sysclk,
  input  logic                            reset,
  input  logic                            UART_RX,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]     rx_count,
  output logic                            err_frame,
  output logic                            err_overrun,
  input  logic                            err_clear,
  output logic                            busy,
`ifdef UART_RX_PARITY_EN
  output logic                            err_parity_pulse,
`endif
  output logic [2:0]                      dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
    , S_PARITY  = 3'd5
`endif
  } state_t;

  logic                 sync1_q, sync2_q, prev_q;
  logic                 rx_s, fall;
  logic [15:0]          div_cnt_q, div_cnt_d;
  logic                 tick, start_det;
  state_t               state_q, state_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 push_req, frame_evt;
`ifdef UART_RX_PARITY_EN
  logic                 par_evt, par_pulse_q;
`endif

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 full, push, pop, overrun_evt;
  logic                 err_frame_q, err_frame_d, err_overrun_q, err_overrun_d;

  assign rx_s = sync2_q;
  assign fall = prev_q & ~rx_s;
  assign tick = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? 16'd0 : div_cnt_q + 16'd1;
    if (start_det) div_cnt_d = 16'd0;
  end

  // Bit timing: tick_cnt counts oversample ticks within a bit; 8 ticks centres on
  // the start bit, every 16th tick after that lands mid-bit.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    push_req   = 1'b0;
    frame_evt  = 1'b0;
    start_det  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_evt    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d    = S_START;
          tick_cnt_d = 4'd0;
          start_det  = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = 4'd0;
            bit_cnt_d  = 4'd0;
            state_d    = rx_s ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
              bit_cnt_d = 4'd0;
`ifdef UART_RX_PARITY_EN
              state_d   = S_PARITY;
`else
              state_d   = S_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            if (rx_s != ^shreg_q) begin
              frame_evt = 1'b1;
              par_evt   = 1'b1;
              state_d   = S_WAIT_HIGH;
            end else begin
              state_d   = S_STOP;
            end
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            if (!rx_s) begin
              frame_evt = 1'b1;
              state_d   = S_WAIT_HIGH;
            end else if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
              push_req  = 1'b1;
              state_d   = S_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
      end
      // A held-low line (break) must not look like a fresh start bit.
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stream handshake: rx_data is the FIFO head whenever rx_valid is high; the
  // head is consumed on a cycle with rx_valid && rx_ready and the next head
  // appears on the following cycle. rx_valid never depends on rx_ready.
  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign rx_valid    = (count_q != '0);
  assign pop         = rx_valid & rx_ready;
  assign push        = push_req & (~full | pop);
  assign overrun_evt = push_req & full & ~pop;
  assign count_d     = count_q + CW'(push) - CW'(pop);

  assign err_frame_d   = frame_evt   | (err_frame_q   & ~err_clear);
  assign err_overrun_d = overrun_evt | (err_overrun_q & ~err_clear);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      prev_q        <= 1'b1;
      div_cnt_q     <= 16'd0;
      state_q       <= S_IDLE;
      tick_cnt_q    <= 4'd0;
      bit_cnt_q     <= 4'd0;
      shreg_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef UART_RX_PARITY_EN
      par_pulse_q   <= 1'b0;
`endif
    end else begin
      sync1_q       <= UART_RX;
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      div_cnt_q     <= div_cnt_d;
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      count_q       <= count_d;
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
      if (push) begin
        mem_q[wr_ptr_q] <= shreg_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
`ifdef UART_RX_PARITY_EN
      par_pulse_q   <= par_evt;
`endif
    end
  end

  assign rx_data     = mem_q[rd_ptr_q];
  assign rx_count    = count_q;
  assign err_frame   = err_frame_q;
  assign err_overrun = err_overrun_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;
`ifdef UART_RX_PARITY_EN
  assign err_parity_pulse = par_pulse_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue-based FIFO/flag model checked every cycle,
// plus literal checks of the test-plan outcomes.
module tb_uart_rx_fifo;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int DEPTH     = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // 2 sync stages + edge register, then 8 ticks to the start-bit centre (1 tick/clk).
  localparam int START_LAT    = 11;
  localparam int PUSH_LAT     = START_LAT + 16 * (DATA_BITS + PAR + STOP_BITS);
  localparam int STOP_ERR_LAT = START_LAT + 16 * (DATA_BITS + PAR + 1);
  localparam int PAR_ERR_LAT  = START_LAT + 16 * (DATA_BITS + 1);

  logic       sysclk, reset, UART_RX, rx_ready, err_clear;
  logic [7:0] rx_data;
  logic       rx_valid, err_frame, err_overrun, busy;
  logic [2:0] rx_count;
  logic [2:0] dbg_state;
`ifdef UART_RX_PARITY_EN
  logic       err_parity_pulse;
  int         pulse_seen;
`endif

  uart_rx_fifo #(.BAUD_DIV(1), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS), .FIFO_DEPTH(DEPTH)) dut (
    .sysclk(sysclk), .reset(reset), .UART_RX(UART_RX),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_count(rx_count),
    .err_frame(err_frame), .err_overrun(err_overrun), .err_clear(err_clear), .busy(busy),
`ifdef UART_RX_PARITY_EN
    .err_parity_pulse(err_parity_pulse),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // model state
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       exp_frame, exp_overrun, exp_pulse;
  int         cyc;
  logic       pend_valid;
  int         pend_cyc, pend_kind;
  logic [7:0] pend_data;
  logic       check_on;
  int         n_cmp, n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue; a frame's outcome lands at a fixed cycle after its start.
  always @(posedge sysclk) begin
    logic do_pop, good, ev_frame, ev_par, ev_ovr;
    cyc++;
    do_pop   = (exp_q.size() > 0) && rx_ready;
    good     = 1'b0;
    ev_frame = 1'b0;
    ev_par   = 1'b0;
    ev_ovr   = 1'b0;
    if (pend_valid && cyc == pend_cyc) begin
      pend_valid = 1'b0;
      if (pend_kind == 0) good = 1'b1;
      else ev_frame = 1'b1;
      if (pend_kind == 2) ev_par = 1'b1;
    end
    if (good && exp_q.size() == DEPTH && !do_pop) ev_ovr = 1'b1;
    if (do_pop) void'(exp_q.pop_front());
    if (good && !ev_ovr) exp_q.push_back(pend_data);
    exp_frame   = ev_frame | (exp_frame & !err_clear);
    exp_overrun = ev_ovr | (exp_overrun & !err_clear);
    exp_pulse   = ev_par;
  end

  // compare process
  always @(negedge sysclk) begin
    if (check_on) begin
      chk("rx_valid", {31'd0, rx_valid}, {31'd0, exp_q.size() != 0});
      chk("rx_count", {29'd0, rx_count}, exp_q.size());
      if (exp_q.size() != 0) chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q[0]});
      chk("err_frame", {31'd0, err_frame}, {31'd0, exp_frame});
      chk("err_overrun", {31'd0, err_overrun}, {31'd0, exp_overrun});
`ifdef UART_RX_PARITY_EN
      chk("err_parity_pulse", {31'd0, err_parity_pulse}, {31'd0, exp_pulse});
`endif
    end
  end

`ifdef UART_RX_PARITY_EN
  always @(negedge sysclk) if (err_parity_pulse) pulse_seen++;
`endif

  // driver tasks (called on a negedge)
  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // kind: 0 good frame, 1 stop bit low, 2 wrong parity bit
  task automatic send(input logic [7:0] d, input int kind);
    pend_data  = d;
    pend_kind  = kind;
    pend_cyc   = cyc + ((kind == 1) ? STOP_ERR_LAT : (kind == 2) ? PAR_ERR_LAT : PUSH_LAT);
    pend_valid = 1'b1;
    UART_RX = 1'b0;
    repeat (16) @(negedge sysclk);
    for (int i = 0; i < DATA_BITS; i++) begin
      UART_RX = d[i];
      repeat (16) @(negedge sysclk);
    end
`ifdef UART_RX_PARITY_EN
    UART_RX = (^d) ^ (kind == 2);
    repeat (16) @(negedge sysclk);
`endif
    for (int i = 0; i < STOP_BITS; i++) begin
      UART_RX = (kind == 1) ? 1'b0 : 1'b1;
      repeat (16) @(negedge sysclk);
    end
    UART_RX = 1'b1;
  endtask

  task automatic pop_n(input int n);
    got_q.delete();
    for (int i = 0; i < n; i++) begin
      got_q.push_back(rx_data);
      rx_ready = 1'b1;
      @(negedge sysclk);
    end
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(negedge sysclk);
    err_clear = 1'b0;
    @(negedge sysclk);
  endtask

  initial begin
    int waited;
    UART_RX = 1'b1; rx_ready = 1'b0; err_clear = 1'b0; reset = 1'b1;
    check_on = 1'b0; n_cmp = 0; n_bad = 0; cyc = 0; pend_valid = 1'b0;
    pend_cyc = 0; pend_kind = 0; pend_data = 8'h00;
    exp_frame = 1'b0; exp_overrun = 1'b0; exp_pulse = 1'b0;
`ifdef UART_RX_PARITY_EN
    pulse_seen = 0;
`endif
    #2 reset = 1'b0;
    idle(3);
    chk("reset_rx_valid", {31'd0, rx_valid}, 0);
    chk("reset_rx_count", {29'd0, rx_count}, 0);
    chk("reset_rx_data", {24'd0, rx_data}, 0);
    chk("reset_err_frame", {31'd0, err_frame}, 0);
    chk("reset_err_overrun", {31'd0, err_overrun}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    reset = 1'b1;
    check_on = 1'b1;
    idle(4);

    // 1: single character
    send(8'hA5, 0); idle(4);
    chk("t1_count", {29'd0, rx_count}, 1);
    chk("t1_data", {24'd0, rx_data}, 32'hA5);
    chk("t1_flags", {30'd0, err_frame, err_overrun}, 0);
    pop_n(1);
    chk("t1_empty", {31'd0, rx_valid}, 0);

    // push into an empty FIFO with rx_ready already high
    rx_ready = 1'b1;
    send(8'h5A, 0); idle(4);
    rx_ready = 1'b0;
    chk("empty_pushpop_count", {29'd0, rx_count}, 0);

    // 2: overrun on a full FIFO
    send(8'h11, 0); idle(4);
    send(8'h22, 0); idle(4);
    send(8'h33, 0); idle(4);
    send(8'h44, 0); idle(4);
    send(8'h55, 0); idle(4);
    chk("t2_count", {29'd0, rx_count}, 4);
    chk("t2_overrun", {31'd0, err_overrun}, 1);
    pop_n(4);
    chk("t2_pop0", {24'd0, got_q[0]}, 32'h11);
    chk("t2_pop1", {24'd0, got_q[1]}, 32'h22);
    chk("t2_pop2", {24'd0, got_q[2]}, 32'h33);
    chk("t2_pop3", {24'd0, got_q[3]}, 32'h44);
    chk("t2_empty", {31'd0, rx_valid}, 0);
    pulse_clear();
    chk("t2_overrun_cleared", {31'd0, err_overrun}, 0);

    // 3: framing error, with err_clear coinciding with the error event
    fork
      send(8'h3C, 1);
      begin
        repeat (STOP_ERR_LAT - 1) @(negedge sysclk);
        err_clear = 1'b1;
        @(negedge sysclk);
        err_clear = 1'b0;
      end
    join
    idle(8);
    chk("t3_err_frame", {31'd0, err_frame}, 1);
    chk("t3_count", {29'd0, rx_count}, 0);
    pulse_clear();
    chk("t3_err_cleared", {31'd0, err_frame}, 0);
    send(8'h3C, 0); idle(4);
    chk("t3_good_data", {24'd0, rx_data}, 32'h3C);
    chk("t3_good_count", {29'd0, rx_count}, 1);
    pop_n(1);

    // 4: 4-clock glitch is a false start
    UART_RX = 1'b0;
    idle(4);
    UART_RX = 1'b1;
    chk("t4_busy_set", {31'd0, busy}, 1);
    waited = 0;
    while (busy && waited < 20) begin
      @(negedge sysclk);
      waited++;
    end
    chk("t4_busy_cleared", {31'd0, busy}, 0);
    idle(4);
    chk("t4_count", {29'd0, rx_count}, 0);
    chk("t4_flags", {30'd0, err_frame, err_overrun}, 0);

    // 5: push and pop on the same cycle while full
    send(8'h61, 0); idle(4);
    send(8'h62, 0); idle(4);
    send(8'h63, 0); idle(4);
    send(8'h64, 0); idle(4);
    fork
      send(8'h66, 0);
      begin
        repeat (PUSH_LAT - 1) @(negedge sysclk);
        rx_ready = 1'b1;
        @(negedge sysclk);
        rx_ready = 1'b0;
      end
    join
    idle(4);
    chk("t5_count", {29'd0, rx_count}, 4);
    chk("t5_overrun", {31'd0, err_overrun}, 0);
    pop_n(4);
    chk("t5_first", {24'd0, got_q[0]}, 32'h62);
    chk("t5_last", {24'd0, got_q[3]}, 32'h66);
    chk("t5_empty", {31'd0, rx_valid}, 0);

`ifdef UART_RX_PARITY_EN
    // 6: even parity
    send(8'h07, 2); idle(8);
    chk("t6_pulse_count", pulse_seen, 1);
    chk("t6_err_frame", {31'd0, err_frame}, 1);
    chk("t6_count", {29'd0, rx_count}, 0);
    pulse_clear();
    send(8'h07, 0); idle(4);
    chk("t6_good_data", {24'd0, rx_data}, 32'h07);
    chk("t6_pulse_count_after", pulse_seen, 1);
    pop_n(1);
`endif

    // reset mid-frame with a character buffered
    send(8'h42, 0); idle(4);
    UART_RX = 1'b0;
    idle(60);
    check_on = 1'b0;
    reset = 1'b0;
    idle(2);
    chk("midreset_count", {29'd0, rx_count}, 0);
    chk("midreset_valid", {31'd0, rx_valid}, 0);
    chk("midreset_busy", {31'd0, busy}, 0);
    chk("midreset_data", {24'd0, rx_data}, 0);
    UART_RX = 1'b1;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
